// File: rtl/scsi_fifo_unpack.sv
// scsi_fifo_unpack: FIFO-to-SCSI transmit engine for the DMA write path.
// Each 32-bit FIFO word is split into two 16-bit halfwords, upper half first.
// Every halfword goes out on the SCSI data bus with a DACK_/IOW_ handshake.
// All bus-side outputs are flops loaded from the next-state decode.
// FIFO_RD is the exception: it is the FETCH state gated by FIFO_EMPTY, so the
// pop lands in the same cycle the word is captured.
module scsi_fifo_unpack #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        START_LO,
    input  logic [15:0] LEN,
    input  logic        ABORT,
    input  logic [31:0] FIFO_OD,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RD,
    input  logic        DREQ_,
    output logic        DACK_,
    output logic        IOW_,
    output logic [15:0] PD_OUT,
    output logic        PD_OE,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] REMAIN
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_REQ,
        SETUP,
        STROBE,
        HOLD,
        FIN
    } state_t;

    localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYCLES - 1);
    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);
    localparam logic [2:0] HOLD_LAST   = 3'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hold_word;
    logic [31:0] hold_nxt;
    logic        half_lo;
    logic        half_nxt;
    logic [2:0]  phase;
    logic [2:0]  phase_nxt;
    logic [15:0] remain_nxt;
    logic [15:0] remain_dec;
    logic        zero_done;
    logic        on_bus;
    logic        dack_nxt;
    logic        iow_nxt;
    logic        oe_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic [15:0] pd_nxt;

    assign FIFO_RD = (state == FETCH) && !FIFO_EMPTY;

    // Next-state, datapath and registered-output decode; ABORT overrides everything
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_word;
        half_nxt   = half_lo;
        phase_nxt  = phase;
        remain_nxt = REMAIN;
        zero_done  = 1'b0;
        remain_dec = (REMAIN != 16'd0) ? REMAIN - 16'd1 : 16'd0;

        if (ABORT) begin
            state_nxt = IDLE;
            half_nxt  = 1'b0;
            phase_nxt = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if (LEN != 16'd0) begin
                            remain_nxt = LEN;
                            half_nxt   = START_LO;
                            state_nxt  = FETCH;
                        end else begin
                            zero_done = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (!FIFO_EMPTY) begin
                        hold_nxt  = FIFO_OD;
                        state_nxt = WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (!DREQ_) begin
                        phase_nxt = 3'd0;
                        state_nxt = SETUP;
                    end
                end
                SETUP: begin
                    if (phase == SETUP_LAST) begin
                        phase_nxt = 3'd0;
                        state_nxt = STROBE;
                    end else begin
                        phase_nxt = phase + 3'd1;
                    end
                end
                STROBE: begin
                    if (phase == STROBE_LAST) begin
                        phase_nxt = 3'd0;
                        state_nxt = HOLD;
                    end else begin
                        phase_nxt = phase + 3'd1;
                    end
                end
                HOLD: begin
                    if (phase == HOLD_LAST) begin
                        phase_nxt  = 3'd0;
                        remain_nxt = remain_dec;
                        if (remain_dec == 16'd0) begin
                            state_nxt = FIN;
                        end else if (!half_lo) begin
                            half_nxt  = 1'b1;
                            state_nxt = WAIT_REQ;
                        end else begin
                            half_nxt  = 1'b0;
                            state_nxt = FETCH;
                        end
                    end else begin
                        phase_nxt = phase + 3'd1;
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        on_bus   = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
        dack_nxt = !on_bus;
        iow_nxt  = (state_nxt != STROBE);
        oe_nxt   = on_bus;
        pd_nxt   = on_bus ? (half_nxt ? hold_nxt[15:0] : hold_nxt[31:16]) : 16'd0;
        busy_nxt = on_bus || (state_nxt == FETCH) || (state_nxt == WAIT_REQ);
        done_nxt = zero_done || (state_nxt == FIN);
    end

    // State, hold register, counters and output flops with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            hold_word <= 32'd0;
            half_lo   <= 1'b0;
            phase     <= 3'd0;
            REMAIN    <= 16'd0;
            DACK_     <= 1'b1;
            IOW_      <= 1'b1;
            PD_OUT    <= 16'd0;
            PD_OE     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_word <= hold_nxt;
            half_lo   <= half_nxt;
            phase     <= phase_nxt;
            REMAIN    <= remain_nxt;
            DACK_     <= dack_nxt;
            IOW_      <= iow_nxt;
            PD_OUT    <= pd_nxt;
            PD_OE     <= oe_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_scsi_fifo_unpack.sv
// tb_scsi_fifo_unpack: directed and randomized transfers against a halfword-list model.
module tb_scsi_fifo_unpack;

    localparam int STROBE_W = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        START_LO;
    logic [15:0] LEN;
    logic        ABORT;
    logic [31:0] FIFO_OD;
    logic        FIFO_EMPTY;
    logic        FIFO_RD;
    logic        DREQ_;
    logic        DACK_;
    logic        IOW_;
    logic [15:0] PD_OUT;
    logic        PD_OE;
    logic        BUSY;
    logic        DONE;
    logic [15:0] REMAIN;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] word_src[$];
    bit          fifo_block;
    bit          pop_pending;

    logic [15:0] got[$];
    int cyc, pops, done_cnt, strobe_starts, strobes_done, low_len;
    int first_rd, first_dack, first_iow, done_cyc;
    bit prev_iow, bad_data, bad_hs, bad_width, any_busy;

    logic        s_rd, s_dack, s_iow, s_oe, s_busy, s_done;
    logic [15:0] s_pd, s_remain;

    scsi_fifo_unpack dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .START_LO   (START_LO),
        .LEN        (LEN),
        .ABORT      (ABORT),
        .FIFO_OD    (FIFO_OD),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RD    (FIFO_RD),
        .DREQ_      (DREQ_),
        .DACK_      (DACK_),
        .IOW_       (IOW_),
        .PD_OUT     (PD_OUT),
        .PD_OE      (PD_OE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .REMAIN     (REMAIN)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveFifo();
        FIFO_EMPTY = (fifo_q.size() == 0) || fifo_block;
        FIFO_OD    = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic resetMonitor();
        got.delete();
        cyc = 0; pops = 0; done_cnt = 0; strobe_starts = 0; strobes_done = 0; low_len = 0;
        first_rd = -1; first_dack = -1; first_iow = -1; done_cyc = -1;
        prev_iow = 1'b1; bad_data = 1'b0; bad_hs = 1'b0; bad_width = 1'b0; any_busy = 1'b0;
        pop_pending = 1'b0;
    endtask

    task automatic tick();
        @(negedge CLK);
        s_rd = FIFO_RD; s_dack = DACK_; s_iow = IOW_; s_oe = PD_OE;
        s_busy = BUSY; s_done = DONE; s_pd = PD_OUT; s_remain = REMAIN;
        if (s_busy) any_busy = 1'b1;
        if (s_rd) begin
            pops++;
            pop_pending = 1'b1;
            if (first_rd < 0) first_rd = cyc;
        end
        if (!s_dack && first_dack < 0) first_dack = cyc;
        if (s_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (!s_iow) begin
            if (prev_iow) begin
                got.push_back(s_pd);
                low_len = 0;
                strobe_starts++;
                if (first_iow < 0) first_iow = cyc;
            end
            low_len++;
            if (got.size() != 0 && s_pd !== got[got.size()-1]) bad_data = 1'b1;
            if (s_dack !== 1'b0 || s_oe !== 1'b1) bad_hs = 1'b1;
        end else if (!prev_iow) begin
            strobes_done++;
            if (low_len != STROBE_W) bad_width = 1'b1;
        end
        prev_iow = s_iow;
        @(posedge CLK);
        #1;
        cyc++;
        if (pop_pending) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_pending = 1'b0;
        end
        driveFifo();
    endtask

    task automatic applyStimulus(input int len, input bit lo, input int dreq_mode,
                                 input int empty_mode, input bit do_abort, input bit chk_lat);
        logic [15:0] exp_hw[$];
        logic [31:0] w;
        int nwords, s, stall_left, block_left, resume_cnt;
        bit stalled, blocked, unblock_chk, abort_next, abort_armed, aborted;
        nwords = (len + int'(lo) + 1) / 2;
        stall_left = 0; block_left = 0; resume_cnt = 0;
        stalled = 0; blocked = 0; unblock_chk = 0; abort_next = 0; abort_armed = 0; aborted = 0;
        resetMonitor();
        if (word_src.size() == 0)
            for (int i = 0; i < nwords; i++) word_src.push_back($urandom);
        fifo_q = word_src;
        word_src.delete();
        exp_hw.delete();
        for (int i = 0; i < fifo_q.size(); i++) begin
            w = fifo_q[i];
            exp_hw.push_back(w[31:16]);
            exp_hw.push_back(w[15:0]);
        end
        if (lo) void'(exp_hw.pop_front());
        while (exp_hw.size() > len) void'(exp_hw.pop_back());

        LEN = 16'(len); START_LO = lo; START = 1'b1; ABORT = 1'b0; DREQ_ = 1'b0;
        fifo_block = 1'b0;
        driveFifo();
        tick();
        START = 1'b0;

        while (done_cnt == 0 && !aborted && cyc < 400) begin
            case (dreq_mode)
                0:       DREQ_ = 1'b0;
                1:       DREQ_ = ($urandom_range(0, 3) != 0);
                default: DREQ_ = (stall_left > 0);
            endcase
            if (empty_mode == 1) fifo_block = ($urandom_range(0, 2) == 0);
            else                 fifo_block = (block_left > 0);
            ABORT = abort_next;
            driveFifo();
            s = cyc;
            tick();
            if (s == 1) begin
                checkOutput("busy_c1", 32'(s_busy), 32'd1);
                checkOutput("remain_c1", 32'(s_remain), 32'(len));
            end
            if (resume_cnt > 0) begin
                resume_cnt--;
                if (resume_cnt == 0) checkOutput("resume_dack", 32'(s_dack), 32'd0);
            end
            if (stall_left > 0) begin
                checkOutput("stall_dack", 32'(s_dack), 32'd1);
                checkOutput("stall_oe", 32'(s_oe), 32'd0);
                stall_left--;
                if (stall_left == 0) resume_cnt = 2;
            end else if (dreq_mode == 2 && !stalled && strobes_done == 1) begin
                stall_left = 10;
                stalled = 1'b1;
            end
            if (block_left > 0) begin
                checkOutput("empty_no_rd", 32'(s_rd), 32'd0);
                block_left--;
                if (block_left == 0) unblock_chk = 1'b1;
            end else if (unblock_chk) begin
                checkOutput("pop_on_nonempty", 32'(s_rd), 32'd1);
                unblock_chk = 1'b0;
            end else if (empty_mode == 2 && !blocked && strobes_done == 2) begin
                block_left = 8;
                blocked = 1'b1;
            end
            if (abort_next) begin
                abort_next = 1'b0;
                ABORT = 1'b0;
                aborted = 1'b1;
            end else if (do_abort && !abort_armed && strobe_starts == 3 && low_len == 1 && !s_iow) begin
                abort_next = 1'b1;
                abort_armed = 1'b1;
            end
        end
        ABORT = 1'b0;
        DREQ_ = 1'b0;
        fifo_block = 1'b0;
        driveFifo();

        if (do_abort) begin
            tick();
            checkOutput("abort_iow", 32'(s_iow), 32'd1);
            checkOutput("abort_dack", 32'(s_dack), 32'd1);
            checkOutput("abort_oe", 32'(s_oe), 32'd0);
            checkOutput("abort_busy", 32'(s_busy), 32'd0);
            checkOutput("abort_remain", 32'(s_remain), 32'(len - 2));
            for (int i = 0; i < 10; i++) tick();
            checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
            checkOutput("abort_pops", 32'(pops), 32'd2);
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("abort_hw%0d", i),
                            (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_hw[i]));
        end else begin
            if (done_cnt == 0) checkOutput("timeout", 32'd0, 32'd1);
            for (int i = 0; i < 3; i++) tick();
            checkOutput("done_once", 32'(done_cnt), 32'd1);
            checkOutput("pops", 32'(pops), 32'(nwords));
            checkOutput("strobes", 32'(strobe_starts), 32'(len));
            checkOutput("strobe_width", 32'(bad_width), 32'd0);
            checkOutput("data_stable", 32'(bad_data), 32'd0);
            checkOutput("handshake", 32'(bad_hs), 32'd0);
            checkOutput("remain_end", 32'(s_remain), 32'd0);
            checkOutput("busy_end", 32'(s_busy), 32'd0);
            for (int i = 0; i < len; i++)
                checkOutput($sformatf("hw%0d", i),
                            (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_hw[i]));
            if (chk_lat) begin
                checkOutput("lat_rd", 32'(first_rd), 32'd1);
                checkOutput("lat_dack", 32'(first_dack), 32'd3);
                checkOutput("lat_iow", 32'(first_iow), 32'd4);
                checkOutput("lat_done", 32'(done_cyc), 32'd7);
            end
        end
    endtask

    // Directed steps followed by randomized transfers
    initial begin
        RST = 1'b1; START = 1'b0; START_LO = 1'b0; LEN = 16'd0; ABORT = 1'b0; DREQ_ = 1'b1;
        fifo_block = 1'b0;
        fifo_q.delete();
        driveFifo();
        resetMonitor();
        tick();
        tick();
        checkOutput("rst_rd", 32'(s_rd), 32'd0);
        checkOutput("rst_dack", 32'(s_dack), 32'd1);
        checkOutput("rst_iow", 32'(s_iow), 32'd1);
        checkOutput("rst_pd", 32'(s_pd), 32'd0);
        checkOutput("rst_oe", 32'(s_oe), 32'd0);
        checkOutput("rst_busy", 32'(s_busy), 32'd0);
        checkOutput("rst_done", 32'(s_done), 32'd0);
        checkOutput("rst_remain", 32'(s_remain), 32'd0);
        RST = 1'b0;
        tick();

        $display("[TB] single halfword latency");
        applyStimulus(1, 1'b0, 0, 0, 1'b0, 1'b1);

        $display("[TB] one word DEADBEEF");
        word_src.push_back(32'hDEADBEEF);
        applyStimulus(2, 1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] odd alignment, five halfwords");
        word_src.push_back(32'h11112222);
        word_src.push_back(32'h33334444);
        word_src.push_back(32'h55556666);
        applyStimulus(5, 1'b1, 0, 0, 1'b0, 1'b0);

        $display("[TB] DREQ_ stall after first halfword");
        applyStimulus(2, 1'b0, 2, 0, 1'b0, 1'b0);

        $display("[TB] FIFO empty at word boundary");
        applyStimulus(4, 1'b0, 0, 2, 1'b0, 1'b0);

        $display("[TB] abort mid-strobe then restart");
        applyStimulus(6, 1'b0, 0, 0, 1'b1, 1'b0);
        applyStimulus(2, 1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] zero length start");
        resetMonitor();
        fifo_q.delete();
        fifo_q.push_back($urandom);
        driveFifo();
        DREQ_ = 1'b0; LEN = 16'd0; START_LO = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        checkOutput("len0_done", 32'(s_done), 32'd1);
        checkOutput("len0_busy", 32'(s_busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("len0_pops", 32'(pops), 32'd0);
        checkOutput("len0_dack", 32'(first_dack), 32'hFFFF_FFFF);
        checkOutput("len0_iow", 32'(strobe_starts), 32'd0);
        checkOutput("len0_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] start with abort");
        resetMonitor();
        LEN = 16'd3; START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sa_busy", 32'(any_busy), 32'd0);
        checkOutput("sa_pops", 32'(pops), 32'd0);
        checkOutput("sa_done", 32'(done_cnt), 32'd0);

        $display("[TB] reset mid-transfer");
        resetMonitor();
        fifo_q.delete();
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        driveFifo();
        LEN = 16'd4; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("pre_rst_remain", 32'(s_remain), 32'd4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        checkOutput("mid_rst_remain", 32'(s_remain), 32'd0);
        checkOutput("mid_rst_busy", 32'(s_busy), 32'd0);
        checkOutput("mid_rst_iow", 32'(s_iow), 32'd1);
        checkOutput("mid_rst_dack", 32'(s_dack), 32'd1);
        checkOutput("mid_rst_oe", 32'(s_oe), 32'd0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 10; t++)
            applyStimulus(int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)), 1, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
